// File: rtl/bus_txn_sched_if.sv
// Bus-side signals of the transaction scheduler: master requests, address strobe,
// slave ready and the scheduler's grant/status outputs.
interface bus_txn_sched_if;
    logic [3:0] m_req;
    logic       m_as;
    logic       s_ready;
    logic [3:0] m_grant;
    logic       txn_done;
    logic       bus_err;
    logic       busy;

    modport slave (
        input  m_req, m_as, s_ready,
        output m_grant, txn_done, bus_err, busy
    );

    modport master (
        output m_req, m_as, s_ready,
        input  m_grant, txn_done, bus_err, busy
    );
endinterface

// File: rtl/bus_txn_sched.sv
// Four-master round-robin bus scheduler with per-transaction timeout abort and
// burst-length fairness limit.
module bus_txn_sched #(
    parameter int TIMEOUT   = 255,
    parameter int BURST_MAX = 4
) (
    input  logic           clk,
    input  logic           reset,
    bus_txn_sched_if.slave bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OWN  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_ERR  = 2'd3;

    localparam logic [7:0] TCNT_LAST = 8'(TIMEOUT - 1);
    localparam logic [3:0] BCNT_MAX  = 4'(BURST_MAX);

    logic [1:0] state_reg, state_next;
    logic [3:0] grant_reg, grant_next;
    logic [1:0] owner_reg, owner_next;
    logic [1:0] rr_ptr_reg, rr_ptr_next;
    logic [7:0] tcnt_reg, tcnt_next;
    logic [3:0] bcnt_reg, bcnt_next;
    logic       txn_done_reg, txn_done_next;
    logic       bus_err_reg, bus_err_next;

    // Requests rotated so that bit 0 is the master at rr_ptr.
    logic [3:0] rot_req;
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_rot
            localparam logic [1:0] OFS = 2'(gi);
            logic [1:0] idx;
            assign idx         = rr_ptr_reg + OFS;
            assign rot_req[gi] = bus.m_req[idx];
        end
    endgenerate

    logic [1:0] win_ofs;
    logic [1:0] winner;
    always_comb begin
        win_ofs = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (rot_req[i]) win_ofs = 2'(i);
        end
    end
    assign winner = rr_ptr_reg + win_ofs;

    logic       complete;
    logic       others_req;
    logic [3:0] bcnt_inc;
    logic [1:0] owner_plus1;
    assign complete    = ((state_reg == ST_OWN) && bus.m_as && bus.s_ready) ||
                         ((state_reg == ST_WAIT) && bus.s_ready);
    assign others_req  = |(bus.m_req & ~grant_reg);
    assign bcnt_inc    = (bcnt_reg >= BCNT_MAX) ? BCNT_MAX : bcnt_reg + 4'd1;
    assign owner_plus1 = owner_reg + 2'd1;

    always_comb begin
        state_next    = state_reg;
        grant_next    = grant_reg;
        owner_next    = owner_reg;
        rr_ptr_next   = rr_ptr_reg;
        tcnt_next     = tcnt_reg;
        bcnt_next     = bcnt_reg;
        txn_done_next = 1'b0;
        bus_err_next  = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                grant_next = 4'b0000;
                if (|bus.m_req) begin
                    // A new ownership always starts a fresh burst count.
                    state_next = ST_OWN;
                    owner_next = winner;
                    grant_next = 4'b0001 << winner;
                    bcnt_next  = 4'd0;
                end
            end
            ST_OWN: begin
                if (bus.m_as && !bus.s_ready) begin
                    state_next = ST_WAIT;
                    tcnt_next  = 8'd0;
                end else if (!bus.m_as && !bus.m_req[owner_reg]) begin
                    state_next  = ST_IDLE;
                    grant_next  = 4'b0000;
                    rr_ptr_next = owner_plus1;
                end
            end
            ST_WAIT: begin
                // Owner request is deliberately ignored here.
                if (!bus.s_ready) begin
                    if (tcnt_reg == TCNT_LAST) begin
                        state_next   = ST_ERR;
                        grant_next   = 4'b0000;
                        bus_err_next = 1'b1;
                    end else begin
                        tcnt_next = tcnt_reg + 8'd1;
                    end
                end
            end
            default: begin
                state_next  = ST_IDLE;
                grant_next  = 4'b0000;
                rr_ptr_next = owner_plus1;
                bcnt_next   = 4'd0;
            end
        endcase

        if (complete) begin
            txn_done_next = 1'b1;
            if (bcnt_inc == BCNT_MAX) begin
                bcnt_next = 4'd0;
                if (others_req) begin
                    state_next  = ST_IDLE;
                    grant_next  = 4'b0000;
                    rr_ptr_next = owner_plus1;
                end else begin
                    state_next = ST_OWN;
                end
            end else begin
                bcnt_next  = bcnt_inc;
                state_next = ST_OWN;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= ST_IDLE;
            grant_reg    <= 4'b0000;
            owner_reg    <= 2'd0;
            rr_ptr_reg   <= 2'd0;
            tcnt_reg     <= 8'd0;
            bcnt_reg     <= 4'd0;
            txn_done_reg <= 1'b0;
            bus_err_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            grant_reg    <= grant_next;
            owner_reg    <= owner_next;
            rr_ptr_reg   <= rr_ptr_next;
            tcnt_reg     <= tcnt_next;
            bcnt_reg     <= bcnt_next;
            txn_done_reg <= txn_done_next;
            bus_err_reg  <= bus_err_next;
        end
    end

    assign bus.m_grant  = grant_reg;
    assign bus.txn_done = txn_done_reg;
    assign bus.bus_err  = bus_err_reg;
    assign bus.busy     = (state_reg != ST_IDLE);
endmodule

// File: tb/tb_bus_txn_sched.sv
// Directed bench for bus_txn_sched with TIMEOUT=8 and BURST_MAX=4.
module tb_bus_txn_sched;
    logic clk;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    bus_txn_sched_if bus_if();

    bus_txn_sched #(.TIMEOUT(8), .BURST_MAX(4)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_if.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] g, input logic d,
                           input logic e, input logic b);
        chk1({tag, ".grant"}, bus_if.m_grant, g);
        chk1({tag, ".txn_done"}, {3'b000, bus_if.txn_done}, {3'b000, d});
        chk1({tag, ".bus_err"}, {3'b000, bus_if.bus_err}, {3'b000, e});
        chk1({tag, ".busy"}, {3'b000, bus_if.busy}, {3'b000, b});
    endtask

    // Grant must be one-hot or zero at all times.
    always @(negedge clk) begin
        n_checks++;
        assert ($onehot0(bus_if.m_grant)) else begin
            n_fail++;
            $error("FAIL grant_onehot observed=%b expected=onehot_or_zero", bus_if.m_grant);
        end
    end

    initial begin
        reset          = 1'b0;
        bus_if.m_req   = 4'b0000;
        bus_if.m_as    = 1'b0;
        bus_if.s_ready = 1'b0;
        tick();
        chk_out("reset", 4'b0000, 0, 0, 0);
        tick();
        reset = 1'b1;

        // Round-robin from pointer 0, release, handover via an idle cycle
        bus_if.m_req = 4'b1010;
        tick(); chk_out("arb_first", 4'b0010, 0, 0, 1);
        bus_if.m_req = 4'b1000;
        tick(); chk_out("release", 4'b0000, 0, 0, 0);
        tick(); chk_out("arb_next", 4'b1000, 0, 0, 1);
        bus_if.m_req = 4'b0000;
        tick(); chk_out("idle", 4'b0000, 0, 0, 0);

        // Master 0: ready arrives three cycles after the strobe
        bus_if.m_req = 4'b0001;
        tick(); chk_out("own0", 4'b0001, 0, 0, 1);
        bus_if.m_as = 1'b1;
        tick(); chk_out("wait_in", 4'b0001, 0, 0, 1);
        tick(); chk_out("wait_1", 4'b0001, 0, 0, 1);
        tick(); chk_out("wait_2", 4'b0001, 0, 0, 1);
        bus_if.s_ready = 1'b1;
        bus_if.m_as    = 1'b0;
        tick(); chk_out("done", 4'b0001, 1, 0, 1);
        bus_if.s_ready = 1'b0;
        tick(); chk_out("done_end", 4'b0001, 0, 0, 1);

        // Timeout: bus_err on the 9th cycle after WAIT entry
        bus_if.m_as = 1'b1;
        tick(); chk_out("to_wait", 4'b0001, 0, 0, 1);
        bus_if.m_as = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick(); chk_out($sformatf("to_cnt%0d", k), 4'b0001, 0, 0, 1);
        end
        tick(); chk_out("to_err", 4'b0000, 0, 1, 1);
        tick(); chk_out("to_idle", 4'b0000, 0, 0, 0);
        tick(); chk_out("to_regrant", 4'b0001, 0, 0, 1);

        // Ready on the last timeout cycle wins; owner drop in WAIT ignored
        bus_if.m_as = 1'b1;
        tick(); chk_out("late_wait", 4'b0001, 0, 0, 1);
        bus_if.m_as  = 1'b0;
        bus_if.m_req = 4'b0000;
        for (int k = 1; k <= 7; k++) begin
            tick(); chk_out($sformatf("late_cnt%0d", k), 4'b0001, 0, 0, 1);
        end
        bus_if.s_ready = 1'b1;
        tick(); chk_out("late_ready", 4'b0001, 1, 0, 1);
        bus_if.s_ready = 1'b0;
        tick(); chk_out("late_drop", 4'b0000, 0, 0, 0);

        // Asynchronous reset mid-WAIT, then arbitration restarts at master 0
        bus_if.m_req = 4'b0010;
        tick(); chk_out("m1_own", 4'b0010, 0, 0, 1);
        bus_if.m_as = 1'b1;
        tick(); chk_out("m1_wait", 4'b0010, 0, 0, 1);
        #2 reset = 1'b0;
        #1 chk_out("async_rst", 4'b0000, 0, 0, 0);
        bus_if.m_as  = 1'b0;
        bus_if.m_req = 4'b1111;
        tick(); chk_out("in_rst", 4'b0000, 0, 0, 0);
        reset = 1'b1;
        tick(); chk_out("post_rst", 4'b0001, 0, 0, 1);

        // Burst limit: yield to master 1 after the 4th completion
        bus_if.m_req   = 4'b0011;
        bus_if.m_as    = 1'b1;
        bus_if.s_ready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick(); chk_out($sformatf("burst%0d", k), 4'b0001, 1, 0, 1);
        end
        tick(); chk_out("burst_yield", 4'b0000, 1, 0, 0);
        bus_if.m_as    = 1'b0;
        bus_if.s_ready = 1'b0;
        tick(); chk_out("burst_m1", 4'b0010, 0, 0, 1);

        // Sole requester keeps the bus across many bursts
        bus_if.m_req = 4'b0001;
        tick(); chk_out("m1_rel", 4'b0000, 0, 0, 0);
        tick(); chk_out("hold_own", 4'b0001, 0, 0, 1);
        bus_if.m_as    = 1'b1;
        bus_if.s_ready = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick(); chk_out($sformatf("hold%0d", k), 4'b0001, 1, 0, 1);
        end
        bus_if.m_as    = 1'b0;
        bus_if.s_ready = 1'b0;
        tick(); chk_out("hold_end", 4'b0001, 0, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/bus_txn_sched.md
BUS_TXN_SCHED -- requirements
Module: bus_txn_sched

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 255, meaning the number of WAIT cycles without s_ready before an abort (legal range 2..255).
REQ-002 The block SHALL have parameter BURST_MAX, default 4, meaning the number of completed transactions after which the owner yields if another master is requesting (legal range 1..15).
REQ-003 The block SHALL have port clk  in  1  system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port m_req  in  4  per-master bus request; bit i belongs to master i.
REQ-006 The block SHALL have port m_as  in  1  address strobe of the currently granted master, taken from the master mux output.
REQ-007 The block SHALL have port s_ready  in  1  ready of the selected slave, taken from the slave mux output.
REQ-008 The block SHALL have port m_grant  out  4  registered one-hot grant, or all-zero.
REQ-009 The block SHALL have port txn_done  out  1  registered one-cycle pulse marking a completed transaction.
REQ-010 The block SHALL have port bus_err  out  1  registered one-cycle pulse marking a timeout abort.
REQ-011 The block SHALL have port busy  out  1  high whenever the state is not IDLE.

Function
REQ-012 The FSM SHALL have the states IDLE, OWN, WAIT and ERR.
REQ-013 IDLE with m_req!=0: the winner SHALL be the first set bit searched from rr_ptr upward, modulo 4; next cycle m_grant=onehot(winner) and state=OWN.
REQ-014 IDLE with m_req==0: m_grant SHALL be 0 and the state SHALL stay IDLE.
REQ-015 OWN with owner req low and m_as low: go to IDLE, clear m_grant, set rr_ptr=owner+1 mod 4.
REQ-016 OWN with m_as high and s_ready low: go to WAIT and load tcnt=0.
REQ-017 OWN with m_as and s_ready both high: the transaction completes in that cycle; apply the completion rule.
REQ-018 WAIT with s_ready high: apply the completion rule.
REQ-019 WAIT with s_ready low: tcnt SHALL increment; when tcnt==TIMEOUT-1 go to ERR.
REQ-020 A simultaneous s_ready and timeout SHALL be resolved in favour of s_ready (normal completion).
REQ-021 Completion rule: pulse txn_done next cycle and increment bcnt.
REQ-022 Completion rule, bcnt reaching BURST_MAX with any other m_req bit high: go to IDLE, clear m_grant, set rr_ptr=owner+1, clear bcnt.
REQ-023 Completion rule, bcnt reaching BURST_MAX with no other requester: stay in OWN and clear bcnt.
REQ-024 Completion rule, all other cases: go to OWN.
REQ-025 ERR SHALL last exactly 1 cycle with bus_err=1 and m_grant=0, then go to IDLE with rr_ptr=owner+1 and bcnt=0.
REQ-026 Owner req dropping while in WAIT SHALL be ignored; the transaction still completes or times out.
REQ-027 A grant handover SHALL always pass through IDLE, so there is at least one all-zero m_grant cycle between owners.
REQ-028 m_grant SHALL never have more than one bit set.
REQ-029 m_grant SHALL never change while in WAIT.
REQ-030 tcnt SHALL be 8 bits and SHALL not wrap.
REQ-031 bcnt SHALL be 4 bits and SHALL saturate at BURST_MAX.

Reset
REQ-032 reset low SHALL immediately force state=IDLE, m_grant=0, txn_done=0, bus_err=0, busy=0, rr_ptr=0, tcnt=0 and bcnt=0, regardless of clk.
REQ-033 Reset asserted mid-WAIT SHALL abort the transaction with no txn_done or bus_err pulse.
REQ-034 The first arbitration after reset release SHALL start at rr_ptr=0.

Verification
REQ-035 Reset then m_req=4'b1010: m_grant=4'b0010 one cycle later; drop req1 with m_as low -> m_grant=0 next cycle, then 4'b1000 the cycle after.
REQ-036 Master 0 owns the bus; m_as=1 and s_ready asserted 3 cycles later -> one txn_done pulse, no bus_err, m_grant stays 4'b0001.
REQ-037 TIMEOUT=8, s_ready held low after m_as -> bus_err pulses exactly 1 cycle on the 9th cycle after WAIT entry, with m_grant=0 in that cycle.
REQ-038 TIMEOUT=8, s_ready rises on the same cycle tcnt==7 -> txn_done=1 and bus_err=0.
REQ-039 BURST_MAX=4, m_req=4'b0011, master 0 issues back-to-back transactions -> grant moves to master 1 after exactly the 4th txn_done; with m_req=4'b0001 the grant is held indefinitely.
REQ-040 reset pulsed low mid-WAIT -> all outputs are 0 asynchronously, and after release m_req=4'b1111 grants master 0 first.
